// File: rtl/decoder_table_loader_pkg.sv
// Shared definitions for the decoder table loader.
//   push_code_e : command encoding driven on dec_push_code
//   state_e     : loader FSM states
package decoder_table_loader_pkg;

  typedef enum logic [1:0] {
    CODE_IDLE  = 2'd0,
    CODE_DATA  = 2'd1,
    CODE_LAST  = 2'd2,
    CODE_TABLE = 2'd3
  } push_code_e;

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    ARMED = 3'd3,
    DRAIN = 3'd4,
    ERROR = 3'd5
  } state_e;

endpackage

// File: rtl/decoder_table_loader.sv
// Loads a 2**WIDTH_OUT entry lookup table into a downstream stream decoder and,
// once the table is complete, forwards codewords to it.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   load_req                 : request a (re)load of the decoder table
//   cfg_valid/data/last/ready: table-entry stream (accepted only while loading)
//   s_valid/data/last/ready  : codeword stream (accepted only while armed)
//   dec_push_code, dec_d     : registered command/data to the decoder
//   dec_rst                  : registered synchronous reset pulse to the decoder
//   dec_full                 : decoder almost-full backpressure
//   table_valid, load_err    : status flags
//   entries_loaded           : table entries written since the last clear
module decoder_table_loader
  import decoder_table_loader_pkg::*;
#(
  parameter int WIDTH_IN     = 8,
  parameter int WIDTH_OUT    = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic                 cfg_valid,
  input  logic [WIDTH_IN-1:0]  cfg_data,
  input  logic                 cfg_last,
  output logic                 cfg_ready,
  input  logic                 s_valid,
  input  logic [WIDTH_IN-1:0]  s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [1:0]           dec_push_code,
  output logic [WIDTH_IN-1:0]  dec_d,
  output logic                 dec_rst,
  input  logic                 dec_full,
  output logic                 table_valid,
  output logic                 load_err,
  output logic [WIDTH_OUT:0]   entries_loaded
);

  localparam int DEPTH = 2 ** WIDTH_OUT;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WIDTH_OUT:0] LAST_IDX   = (WIDTH_OUT + 1)'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] flush_cnt;
  logic             cfg_fire;
  logic             s_fire;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    case (state_q)
      EMPTY: if (load_req) state_d = CLEAR;
      CLEAR: state_d = LOAD;
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          // The DEPTH-th entry must carry cfg_last; any mismatch is an error,
          // but the offending entry is still forwarded.
          if (entries_loaded == LAST_IDX) state_d = cfg_last ? ARMED : ERROR;
          else if (cfg_last)              state_d = ERROR;
        end
      end
      ARMED: begin
        // dec_full is almost-full: stop accepting immediately, the registered
        // output stage may still deliver the one word accepted just before.
        s_ready = !dec_full && !load_req;
        if (load_req) state_d = DRAIN;
      end
      DRAIN: if (flush_cnt == '0) state_d = CLEAR;
      ERROR: if (load_req) state_d = CLEAR;
      default: state_d = EMPTY;
    endcase
  end

  assign cfg_fire    = cfg_valid && cfg_ready;
  assign s_fire      = s_valid && s_ready;
  assign table_valid = (state_q == ARMED);
  assign load_err    = (state_q == ERROR);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= EMPTY;
      dec_push_code  <= CODE_IDLE;
      dec_d          <= '0;
      dec_rst        <= 1'b1;   // decoder held in reset until the first edge after release
      entries_loaded <= '0;
      flush_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      dec_rst       <= (state_q == CLEAR);
      dec_push_code <= CODE_IDLE;
      if (cfg_fire) begin
        dec_push_code <= CODE_TABLE;
        dec_d         <= cfg_data;
      end else if (s_fire) begin
        dec_push_code <= s_last ? CODE_LAST : CODE_DATA;
        dec_d         <= s_data;
      end

      if (state_q == CLEAR)  entries_loaded <= '0;
      else if (cfg_fire)     entries_loaded <= entries_loaded + 1'b1;

      // Loaded on the ARMED->DRAIN edge; DRAIN then lasts FLUSH_CYCLES cycles.
      if (state_q == ARMED && load_req)           flush_cnt <= FLUSH_LOAD;
      else if (state_q == DRAIN && flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
    end
  end

endmodule
